// File: rtl/m8_read_sequencer.sv
// Read-side sequencer for the M8 frame filler: turns serializer word requests into
// filler fetches, waits out the fill latency and returns the captured word.
//
// state  | meaning
// IDLE   | waiting for a request; run control evaluated at frame boundary
// ISSUE  | one-cycle fetch strobe to the filler, latency counter loaded
// WAIT   | counting down the fill latency, capture on the last count
module m8_read_sequencer #(
    parameter int WORDS_PER_FRAME  = 1024,
    parameter int FRAMES_PER_GROUP = 32,
    parameter int FILL_LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wordReq,
    input  logic        clrErr,
    input  logic [11:0] dataWord,
    output logic        bufGetWord,
    output logic [9:0]  bufRdPointer,
    output logic [11:0] wordOut,
    output logic        wordValid,
    output logic        frameStart,
    output logic        groupStart,
    output logic [4:0]  frameCnt,
    output logic        busy,
    output logic        running,
    output logic        overrun
);

    localparam logic [9:0] PTR_LAST   = 10'(WORDS_PER_FRAME - 1);
    localparam logic [4:0] FRAME_LAST = 5'(FRAMES_PER_GROUP - 1);
    localparam logic [2:0] LAT_LOAD   = 3'(FILL_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  ptr_q, ptr_d;
    logic [4:0]  frame_q, frame_d;
    logic        running_q, running_d;
    logic [2:0]  lat_q, lat_d;
    logic [9:0]  cap_idx_q, cap_idx_d;
    logic [11:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        fstart_q, fstart_d;
    logic        gstart_q, gstart_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        frame_d   = frame_q;
        running_d = running_q;
        lat_d     = lat_q;
        cap_idx_d = cap_idx_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        fstart_d  = 1'b0;
        gstart_d  = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (running_q && wordReq) begin
                    state_d = S_ISSUE;
                end
                // Start/stop only at a frame boundary so a frame always completes.
                if (ptr_q == '0) begin
                    running_d = enable;
                end
            end
            S_ISSUE: begin
                lat_d     = LAT_LOAD;
                cap_idx_d = ptr_q;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    word_d   = dataWord;
                    valid_d  = 1'b1;
                    fstart_d = (cap_idx_q == '0);
                    gstart_d = (cap_idx_q == '0) && (frame_q == '0);
                    lat_d    = '0;
                    state_d  = S_IDLE;
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = '0;
                        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 5'd1;
                    end else begin
                        ptr_d = ptr_q + 10'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new overrun outranks a simultaneous clear.
        if (wordReq && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clrErr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            frame_q   <= '0;
            running_q <= 1'b0;
            lat_q     <= '0;
            cap_idx_q <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            fstart_q  <= 1'b0;
            gstart_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            frame_q   <= frame_d;
            running_q <= running_d;
            lat_q     <= lat_d;
            cap_idx_q <= cap_idx_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            fstart_q  <= fstart_d;
            gstart_q  <= gstart_d;
            overrun_q <= overrun_d;
        end
    end

    assign bufGetWord   = (state_q == S_ISSUE);
    assign busy         = (state_q != S_IDLE);
    assign bufRdPointer = ptr_q;
    assign wordOut      = word_q;
    assign wordValid    = valid_q;
    assign frameStart   = fstart_q;
    assign groupStart   = gstart_q;
    assign frameCnt     = frame_q;
    assign running      = running_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_m8_read_sequencer.sv
// Bench for m8_read_sequencer: two instances (latency 1 / 1024-word frames and
// latency 3 / 8-word frames) checked every cycle against a transaction-timeline model.
module tb_m8_read_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        en  [2];
    logic        req [2];
    logic        clr [2];
    logic [11:0] dw  [2];
    logic        get [2];
    logic [9:0]  rdp [2];
    logic [11:0] wout [2];
    logic        wv  [2];
    logic        fs  [2];
    logic        gs  [2];
    logic [4:0]  fcnt [2];
    logic        bsy [2];
    logic        run [2];
    logic        ovr [2];

    m8_read_sequencer #(.WORDS_PER_FRAME(1024), .FRAMES_PER_GROUP(32), .FILL_LATENCY(1)) u_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .wordReq(req[0]), .clrErr(clr[0]),
        .dataWord(dw[0]), .bufGetWord(get[0]), .bufRdPointer(rdp[0]), .wordOut(wout[0]),
        .wordValid(wv[0]), .frameStart(fs[0]), .groupStart(gs[0]), .frameCnt(fcnt[0]),
        .busy(bsy[0]), .running(run[0]), .overrun(ovr[0]));

    m8_read_sequencer #(.WORDS_PER_FRAME(8), .FRAMES_PER_GROUP(32), .FILL_LATENCY(3)) u_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .wordReq(req[1]), .clrErr(clr[1]),
        .dataWord(dw[1]), .bufGetWord(get[1]), .bufRdPointer(rdp[1]), .wordOut(wout[1]),
        .wordValid(wv[1]), .frameStart(fs[1]), .groupStart(gs[1]), .frameCnt(fcnt[1]),
        .busy(bsy[1]), .running(run[1]), .overrun(ovr[1]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int words_of(input int d);
        return (d == 0) ? 1024 : 8;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Filler: the word for pointer p is p ^ key, valid FILL_LATENCY-1 edges after the
    // fetch edge, random junk before that.
    logic [11:0] key [2];
    int f_ptr [2] = '{0, 0};
    int f_cnt [2] = '{0, 0};
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (get[d] === 1'b1) begin
                f_ptr[d] = int'(rdp[d]);
                f_cnt[d] = lat_of(d);
            end
            if (f_cnt[d] > 0) begin
                f_cnt[d]--;
                if (f_cnt[d] == 0) dw[d] <= 12'(f_ptr[d]) ^ key[d];
                else               dw[d] <= 12'($urandom);
            end
        end
    end

    // Model: an accepted request in cycle a is fetched in a+1, busy a+1..a+L+1,
    // delivered in cycle a+L+2.
    int          cyc = 0;
    int          m_ptr [2]   = '{0, 0};
    int          m_fcnt [2]  = '{0, 0};
    int          m_acc [2]   = '{-100, -100};
    int          m_vc [2]    = '{-100, -100};
    int          m_cptr [2]  = '{0, 0};
    int          m_cf [2]    = '{0, 0};
    bit          m_run [2]   = '{1'b0, 1'b0};
    bit          m_ovr [2]   = '{1'b0, 1'b0};
    bit          m_wv [2]    = '{1'b0, 1'b0};
    bit          m_fs [2]    = '{1'b0, 1'b0};
    bit          m_gs [2]    = '{1'b0, 1'b0};
    logic [11:0] m_word [2]  = '{12'h0, 12'h0};
    bit          busy_prev;

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            m_wv[d] = 1'b0;
            m_fs[d] = 1'b0;
            m_gs[d] = 1'b0;
            if (rst[d] !== 1'b0) begin
                m_ptr[d] = 0; m_fcnt[d] = 0; m_run[d] = 1'b0; m_ovr[d] = 1'b0;
                m_word[d] = 12'h0; m_acc[d] = -100; m_vc[d] = -100;
            end else begin
                busy_prev = (cyc - 1 > m_acc[d]) && (cyc - 1 < m_vc[d]);
                if (!busy_prev) begin
                    if (m_run[d] && req[d]) begin
                        m_acc[d]  = cyc - 1;
                        m_vc[d]   = cyc - 1 + lat_of(d) + 2;
                        m_cptr[d] = m_ptr[d];
                        m_cf[d]   = m_fcnt[d];
                    end
                    if (m_ptr[d] == 0) m_run[d] = en[d];
                    if (clr[d]) m_ovr[d] = 1'b0;
                end else begin
                    if (req[d]) m_ovr[d] = 1'b1;
                    else if (clr[d]) m_ovr[d] = 1'b0;
                end
                if (cyc == m_vc[d]) begin
                    m_wv[d]   = 1'b1;
                    m_word[d] = 12'(m_cptr[d]) ^ key[d];
                    m_fs[d]   = (m_cptr[d] == 0);
                    m_gs[d]   = (m_cptr[d] == 0) && (m_cf[d] == 0);
                    m_ptr[d]  = (m_ptr[d] + 1) % words_of(d);
                    if (m_ptr[d] == 0) m_fcnt[d] = (m_fcnt[d] + 1) % 32;
                end
            end
        end
    end

    int wv_cnt [2]  = '{0, 0};
    int fs_cnt [2]  = '{0, 0};
    int gs_cnt [2]  = '{0, 0};
    int get_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk("bufGetWord",   d, 32'(get[d]),  32'(cyc == m_acc[d] + 1));
                chk("busy",         d, 32'(bsy[d]),  32'((cyc > m_acc[d]) && (cyc < m_vc[d])));
                chk("bufRdPointer", d, 32'(rdp[d]),  32'(m_ptr[d]));
                chk("wordValid",    d, 32'(wv[d]),   32'(m_wv[d]));
                chk("wordOut",      d, 32'(wout[d]), 32'(m_word[d]));
                chk("frameStart",   d, 32'(fs[d]),   32'(m_fs[d]));
                chk("groupStart",   d, 32'(gs[d]),   32'(m_gs[d]));
                chk("frameCnt",     d, 32'(fcnt[d]), 32'(m_fcnt[d]));
                chk("running",      d, 32'(run[d]),  32'(m_run[d]));
                chk("overrun",      d, 32'(ovr[d]),  32'(m_ovr[d]));
                if (wv[d] === 1'b1)  wv_cnt[d]++;
                if (fs[d] === 1'b1)  fs_cnt[d]++;
                if (gs[d] === 1'b1)  gs_cnt[d]++;
                if (get[d] === 1'b1) get_cnt[d]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; returns in the cycle the word must be valid.
    task automatic serve(input int d);
        req[d] = 1'b1;
        tick();
        req[d] = 1'b0;
        repeat (lat_of(d) + 1) tick();
    endtask

    task automatic reset_dut(input int d);
        rst[d] = 1'b1;
        tick();
        rst[d] = 1'b0;
    endtask

    int snap0, snap1;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; en[d] = 1'b0; req[d] = 1'b0; clr[d] = 1'b0; key[d] = 12'h0;
        end
        repeat (3) tick();
        chk_on = 1'b1;
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        chk("lit_reset_ptr",  0, 32'(rdp[0]), 32'd0);
        chk("lit_reset_busy", 0, 32'(bsy[0]), 32'd0);

        // Single request, latency 1
        key[0] = 12'h009;
        en[0]  = 1'b1;
        tick();
        snap0 = get_cnt[0];
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        chk("lit_single_get",  0, 32'(get[0]), 32'd1);
        chk("lit_single_ptr",  0, 32'(rdp[0]), 32'd0);
        tick();
        chk("lit_single_get2", 0, 32'(get[0]), 32'd0);
        chk("lit_single_wv2",  0, 32'(wv[0]),  32'd0);
        tick();
        chk("lit_single_wv3",  0, 32'(wv[0]),   32'd1);
        chk("lit_single_word", 0, 32'(wout[0]), 32'h009);
        chk("lit_single_fs",   0, 32'(fs[0]),   32'd1);
        chk("lit_single_gs",   0, 32'(gs[0]),   32'd1);
        tick();
        chk("lit_single_ptr1", 0, 32'(rdp[0]), 32'd1);
        chk("lit_single_ngets",0, 32'(get_cnt[0] - snap0), 32'd1);

        // Full frame plus one word
        reset_dut(0);
        key[0] = 12'h000;
        tick();
        snap0 = fs_cnt[0];
        snap1 = gs_cnt[0];
        for (int i = 0; i < 1025; i++) begin
            serve(0);
            chk("lit_frame_word", 0, 32'(wout[0]), 32'(i % 1024));
        end
        tick();
        chk("lit_frame_fcnt", 0, 32'(fcnt[0]), 32'd1);
        chk("lit_frame_ovr",  0, 32'(ovr[0]),  32'd0);
        chk("lit_frame_nfs",  0, 32'(fs_cnt[0] - snap0), 32'd2);
        chk("lit_frame_ngs",  0, 32'(gs_cnt[0] - snap1), 32'd1);

        // Overrun
        snap0 = get_cnt[0];
        req[0] = 1'b1; tick(); req[0] = 1'b0;
        tick();
        req[0] = 1'b1; tick(); req[0] = 1'b0;
        chk("lit_ovr_set",   0, 32'(ovr[0]), 32'd1);
        tick();
        chk("lit_ovr_ngets", 0, 32'(get_cnt[0] - snap0), 32'd1);
        repeat (4) tick();
        chk("lit_ovr_sticky", 0, 32'(ovr[0]), 32'd1);
        req[0] = 1'b1; tick();
        req[0] = 1'b1; clr[0] = 1'b1; tick();
        req[0] = 1'b0; clr[0] = 1'b0;
        chk("lit_ovr_setwins", 0, 32'(ovr[0]), 32'd1);
        repeat (4) tick();
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        chk("lit_ovr_clear", 0, 32'(ovr[0]), 32'd0);

        // Stop at frame boundary, then restart
        reset_dut(0);
        tick();
        repeat (500) serve(0);
        en[0] = 1'b0;
        repeat (3) tick();
        chk("lit_stop_still_run", 0, 32'(run[0]), 32'd1);
        chk("lit_stop_ptr500",    0, 32'(rdp[0]), 32'd500);
        repeat (524) serve(0);
        tick();
        chk("lit_stop_run",  0, 32'(run[0]),  32'd0);
        chk("lit_stop_fcnt", 0, 32'(fcnt[0]), 32'd1);
        snap0 = get_cnt[0];
        repeat (3) begin
            req[0] = 1'b1; tick(); req[0] = 1'b0; tick(); tick();
        end
        chk("lit_stop_nogets", 0, 32'(get_cnt[0] - snap0), 32'd0);
        chk("lit_stop_noovr",  0, 32'(ovr[0]), 32'd0);
        en[0] = 1'b1;
        tick();
        chk("lit_restart_ptr", 0, 32'(rdp[0]), 32'd0);
        serve(0);
        chk("lit_restart_word", 0, 32'(wout[0]), 32'd0);
        chk("lit_restart_fs",   0, 32'(fs[0]),   32'd1);
        chk("lit_restart_gs",   0, 32'(gs[0]),   32'd0);
        chk("lit_restart_fcnt", 0, 32'(fcnt[0]), 32'd1);

        // Single request, latency 3
        key[1] = 12'h5A5;
        en[1]  = 1'b1;
        tick();
        req[1] = 1'b1; tick(); req[1] = 1'b0;
        chk("lit_l3_get", 1, 32'(get[1]), 32'd1);
        repeat (3) tick();
        chk("lit_l3_wv4", 1, 32'(wv[1]), 32'd0);
        tick();
        chk("lit_l3_wv5",  1, 32'(wv[1]),   32'd1);
        chk("lit_l3_word", 1, 32'(wout[1]), 32'h5A5);

        // Reset while waiting on the filler
        tick();
        req[1] = 1'b1; tick();
        req[1] = 1'b1; tick();
        req[1] = 1'b0;
        chk("lit_rst_pre_busy", 1, 32'(bsy[1]), 32'd1);
        chk("lit_rst_pre_ovr",  1, 32'(ovr[1]), 32'd1);
        rst[1] = 1'b1; tick(); rst[1] = 1'b0;
        chk("lit_rst_busy", 1, 32'(bsy[1]),  32'd0);
        chk("lit_rst_get",  1, 32'(get[1]),  32'd0);
        chk("lit_rst_ptr",  1, 32'(rdp[1]),  32'd0);
        chk("lit_rst_word", 1, 32'(wout[1]), 32'd0);
        chk("lit_rst_run",  1, 32'(run[1]),  32'd0);
        chk("lit_rst_ovr",  1, 32'(ovr[1]),  32'd0);
        snap0 = wv_cnt[1];
        repeat (8) tick();
        chk("lit_rst_nowv", 1, 32'(wv_cnt[1] - snap0), 32'd0);

        // Group wrap on the 8-word instance
        reset_dut(1);
        key[1] = 12'h000;
        tick();
        snap0 = gs_cnt[1];
        snap1 = fs_cnt[1];
        for (int i = 0; i < 264; i++) begin
            serve(1);
            if (i == 247) chk("lit_grp_fcnt31", 1, 32'(fcnt[1]), 32'd31);
            if (i == 255) chk("lit_grp_fcnt0",  1, 32'(fcnt[1]), 32'd0);
        end
        tick();
        chk("lit_grp_ngs", 1, 32'(gs_cnt[1] - snap0), 32'd2);
        chk("lit_grp_nfs", 1, 32'(fs_cnt[1] - snap1), 32'd33);

        // Random traffic on both instances
        for (int d = 0; d < 2; d++) key[d] = 12'(d * 12'h3C3);
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                req[d] = ($urandom_range(0, 3) == 0);
                clr[d] = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 199) == 0) en[d] = ~en[d];
                rst[d] = ($urandom_range(0, 499) == 0);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; clr[d] = 1'b0; rst[d] = 1'b0;
        end
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
